btn_debounce: RTL and testbench

//  Input-side counterpart to the LED output driver. Takes one raw, asynchronous push-button pin,

---
 rtl/btn_debounce.sv | 139 +++++++++++++
 tb/tb_btn_debounce.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchroniser, debounce FSM,
// registered level/press/release/long-hold strobes and a press counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned LONG_CYC     = 50000000,
    parameter int unsigned CNT_W        = 8,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned HW = $clog2(LONG_CYC + 1);

    localparam logic          REL_PIN = logic'(ACTIVE_LOW);
    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] H_MAX   = HW'(LONG_CYC);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        REL_CHK
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             b;

    always_comb begin
        s1_d    = btn_raw;
        s2_d    = s1_q;
        b       = ACTIVE_LOW ? ~s2_q : s2_q;
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        level_d = level_q;
        count_d = count_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;

        unique case (state_q)
            RELEASED: begin
                if (b) begin
                    state_d = PRESS_CHK;
                    dcnt_d  = '0;
                end
            end
            PRESS_CHK: begin
                if (!b) begin
                    state_d = RELEASED;
                end else if (dcnt_q == D_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    count_d = count_q + 1'b1;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            PRESSED, REL_CHK: begin
                // Hold time runs through release bounces; saturation
                // keeps long_pulse to a single shot per press.
                if (hcnt_q != H_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
                long_d = (hcnt_q == H_LAST);
                if (state_q == PRESSED) begin
                    if (!b) begin
                        state_d = REL_CHK;
                        dcnt_d  = '0;
                    end
                end else if (b) begin
                    state_d = PRESSED;
                end else if (dcnt_q == D_LAST) begin
                    state_d = RELEASED;
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            s1_q    <= REL_PIN;
            s2_q    <= REL_PIN;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            count_q <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random runs,
// compared every cycle against a run-length reference model.
module tb_btn_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 16;
    localparam int unsigned CW   = 3;
    localparam bit          AL   = 1'b0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_raw = 1'b0;
    logic          btn_level;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic [CW-1:0] press_count;

    int errors = 0;
    int total  = 0;

    // reference model state
    bit m_level, m_press, m_rel, m_long;
    bit hist0, hist1;
    int m_count, run, hold;

    // per-scenario observations
    int t_idx, n_press, n_rel, n_long, press_idx, long_idx;

    btn_debounce #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LONG),
        .CNT_W       (CW),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Level flips once the pressed/released sample has disagreed
    // with the current level for DEB+1 consecutive edges.
    task automatic model_edge(input bit r, input bit rs);
        bit b;
        m_press = 0;
        m_rel   = 0;
        m_long  = 0;
        if (rs) begin
            hist0   = AL;
            hist1   = AL;
            m_level = 0;
            m_count = 0;
            run     = 0;
            hold    = 0;
        end else begin
            b     = AL ? ~hist1 : hist1;
            hist1 = hist0;
            hist0 = r;
            if (m_level) begin
                hold++;
                if (hold == LONG) m_long = 1;
            end
            run = (b != m_level) ? run + 1 : 0;
            if (run == DEB + 1) begin
                run     = 0;
                m_level = ~m_level;
                if (m_level) begin
                    m_press = 1;
                    m_count = (m_count + 1) % (1 << CW);
                    hold    = 0;
                end else begin
                    m_rel = 1;
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit rs);
        btn_raw = r;
        rst     = rs;
        @(posedge clk);
        model_edge(r, rs);
        @(negedge clk);
        chk("level", btn_level, m_level);
        chk("press", press_pulse, m_press);
        chk("release", release_pulse, m_rel);
        chk("long", long_pulse, m_long);
        chk("count", press_count, m_count);
        if (press_pulse === 1'b1) begin
            if (press_idx < 0) press_idx = t_idx;
            n_press++;
        end
        if (release_pulse === 1'b1) n_rel++;
        if (long_pulse === 1'b1) begin
            if (long_idx < 0) long_idx = t_idx;
            n_long++;
        end
        t_idx++;
    endtask

    task automatic clear_stats();
        t_idx     = 0;
        n_press   = 0;
        n_rel     = 0;
        n_long    = 0;
        press_idx = -1;
        long_idx  = -1;
    endtask

    task automatic do_reset();
        tick(AL, 1);
        tick(AL, 0);
        clear_stats();
    endtask

    task automatic hold_pin(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v, 0);
    endtask

    initial begin
        hist0 = AL;
        hist1 = AL;
        clear_stats();
        do_reset();
        chk("rst_level", btn_level, 0);
        chk("rst_count", press_count, 0);

        // clean press
        hold_pin(1, 30);
        chk("t1_press_idx", press_idx, 6);
        chk("t1_long_idx", long_idx, 22);
        chk("t1_npress", n_press, 1);
        chk("t1_nlong", n_long, 1);
        chk("t1_count", press_count, 1);
        hold_pin(0, 10);
        chk("t1_nrel", n_rel, 1);

        // bounce then steady
        do_reset();
        tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
        hold_pin(1, 12);
        chk("t2_npress", n_press, 1);
        chk("t2_count", press_count, 1);
        chk("t2_level", btn_level, 1);

        // short press
        do_reset();
        hold_pin(1, 3);
        hold_pin(0, 10);
        chk("t3_npress", n_press, 0);
        chk("t3_level", btn_level, 0);
        chk("t3_count", press_count, 0);

        // release glitch
        do_reset();
        hold_pin(1, 10);
        hold_pin(0, 2);
        hold_pin(1, 10);
        chk("t4_nrel", n_rel, 0);
        chk("t4_npress", n_press, 1);
        chk("t4_level", btn_level, 1);

        // counter wrap
        do_reset();
        for (int i = 0; i < 9; i++) begin
            hold_pin(1, 8);
            hold_pin(0, 8);
        end
        chk("t5_nrel", n_rel, 9);
        chk("t5_count", press_count, 1);

        // reset mid-press
        do_reset();
        hold_pin(1, 10);
        chk("t6_pre_level", btn_level, 1);
        tick(1, 1);
        chk("t6_rst_level", btn_level, 0);
        chk("t6_rst_count", press_count, 0);
        n_press = 0;
        hold_pin(1, 12);
        chk("t6_nrel", n_rel, 0);
        chk("t6_npress", n_press, 1);
        chk("t6_count", press_count, 1);

        // random runs with occasional reset
        do_reset();
        for (int i = 0; i < 60; i++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 24));
            hold_pin(v, len);
            if ($urandom_range(0, 15) == 0) tick(v, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
